// File: rtl/imm_ext_pipe_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg -- shared definitions for the immediate-extension pipeline.
//   OPW              : width of the one-hot format select
//   EXT_Z12..EXT_Z6  : bit positions inside ext_op for each immediate format
//   imm_fmt_e        : enumerated format names for decoder / bench use
//   is_onehot()      : legality check for an ext_op vector
// -----------------------------------------------------------------------------
package imm_pkg;

    localparam int OPW = 8;

    localparam int EXT_Z12 = 0;
    localparam int EXT_S12 = 1;
    localparam int EXT_S16 = 2;
    localparam int EXT_S26 = 3;
    localparam int EXT_F20 = 4;
    localparam int EXT_Z5  = 5;
    localparam int EXT_S14 = 6;
    localparam int EXT_Z6  = 7;

    typedef enum logic [2:0] {
        FMT_Z12 = 3'd0,
        FMT_S12 = 3'd1,
        FMT_S16 = 3'd2,
        FMT_S26 = 3'd3,
        FMT_F20 = 3'd4,
        FMT_Z5  = 3'd5,
        FMT_S14 = 3'd6,
        FMT_Z6  = 3'd7
    } imm_fmt_e;

    // True when exactly one bit of the format select is set.
    function automatic logic is_onehot(input logic [OPW-1:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < OPW; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return (cnt == 4'd1);
    endfunction

endpackage

// File: rtl/imm_ext_pipe_if.sv
// -----------------------------------------------------------------------------
// imm_ext_pipe_if -- handshake/data bundle of the immediate-extension pipeline.
//   master : producer/consumer side (decoder, ID/EX stage, bench)
//   slave  : the pipeline itself
//   flush, in_valid/in_ready, instr, pc, ext_op, pc_rel  -- input side
//   out_valid/out_ready, imm_out, op_err                 -- output side
// -----------------------------------------------------------------------------
interface imm_ext_pipe_if
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int W_OP = OPW
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [XLEN-1:0]  pc;
    logic [W_OP-1:0]  ext_op;
    logic             pc_rel;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm_out;
    logic             op_err;

    modport master (
        output flush, in_valid, instr, pc, ext_op, pc_rel, out_ready,
        input  in_ready, out_valid, imm_out, op_err
    );

    modport slave (
        input  flush, in_valid, instr, pc, ext_op, pc_rel, out_ready,
        output in_ready, out_valid, imm_out, op_err
    );
endinterface

// File: rtl/imm_ext_pipe_comb.sv
// -----------------------------------------------------------------------------
// imm_ext_comb -- purely combinational LA64 immediate formatter.
//   i_instr  : raw instruction word
//   i_ext_op : one-hot format select (bit map in imm_pkg)
//   o_imm    : extended immediate, XLEN wide (0 when select is illegal)
//   o_op_err : select was zero or had more than one bit set
// -----------------------------------------------------------------------------
module imm_ext_comb
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int W_OP = OPW
) (
    input  logic [31:0]      i_instr,
    input  logic [W_OP-1:0]  i_ext_op,
    output logic [XLEN-1:0]  o_imm,
    output logic             o_op_err
);

    // Opcode bits never carry immediate payload.
    logic w_unused_opcode;
    assign w_unused_opcode = ^i_instr[31:26];

    // Format select: size casts of signed operands do the sign extension, so
    // the same code serves XLEN 32 and 64 without zero-width replications.
    always_comb begin
        o_imm    = {XLEN{1'b0}};
        o_op_err = 1'b0;
        if (!is_onehot(i_ext_op)) begin
            o_op_err = 1'b1;
        end else begin
            case (1'b1)
                i_ext_op[EXT_Z12]: o_imm = XLEN'(i_instr[21:10]);
                i_ext_op[EXT_S12]: o_imm = XLEN'($signed(i_instr[21:10]));
                i_ext_op[EXT_S16]: o_imm = XLEN'($signed({i_instr[25:10], 2'b00}));
                i_ext_op[EXT_S26]: o_imm = XLEN'($signed({i_instr[9:0], i_instr[25:10], 2'b00}));
                i_ext_op[EXT_F20]: o_imm = XLEN'($signed({i_instr[24:5], 12'h000}));
                i_ext_op[EXT_Z5]:  o_imm = XLEN'(i_instr[14:10]);
                i_ext_op[EXT_S14]: o_imm = XLEN'($signed({i_instr[23:10], 2'b00}));
                i_ext_op[EXT_Z6]:  o_imm = XLEN'(i_instr[15:10]);
                default:           o_imm = {XLEN{1'b0}};
            endcase
        end
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// -----------------------------------------------------------------------------
// imm_ext_pipe -- two-stage pipelined immediate extender with optional
// PC-relative adder, between instruction decode and the ID/EX boundary.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (priority over flush)
//   bus  : imm_ext_pipe_if.slave (input handshake + fields, output handshake,
//          imm_out, op_err)
// Stage 1 holds the formatted immediate, stage 2 holds the final result.
// in_ready is the only combinational path (from out_ready).
// -----------------------------------------------------------------------------
module imm_ext_pipe
    import imm_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int OPW       = imm_pkg::OPW,
    parameter int PC_REL_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    imm_ext_pipe_if.slave bus
);

    logic [XLEN-1:0] w_imm;
    logic            w_err;
    logic            w_s1_adv;
    logic            w_s2_adv;
    logic            w_use_pc;
    logic [XLEN-1:0] w_s2_imm;

    logic            r_s1_valid;
    logic [XLEN-1:0] r_s1_imm;
    logic [XLEN-1:0] r_s1_pc;
    logic            r_s1_pc_rel;
    logic            r_s1_err;
    logic            r_s2_valid;
    logic [XLEN-1:0] r_s2_imm;
    logic            r_s2_err;

    imm_ext_comb #(.XLEN(XLEN), .W_OP(OPW)) u_fmt (
        .i_instr  (bus.instr),
        .i_ext_op (bus.ext_op),
        .o_imm    (w_imm),
        .o_op_err (w_err)
    );

    assign w_s2_adv     = !r_s2_valid || bus.out_ready;
    assign w_s1_adv     = !r_s1_valid || w_s2_adv;
    assign bus.in_ready = w_s1_adv;
    assign bus.out_valid = r_s2_valid;
    assign bus.imm_out   = r_s2_imm;
    assign bus.op_err    = r_s2_err;

    // Stage-2 result: optional PC add; a zero PC_REL_EN folds the adder away.
    always_comb begin
        w_use_pc = (PC_REL_EN != 0) && r_s1_pc_rel;
        if (w_use_pc) begin
            w_s2_imm = r_s1_pc + r_s1_imm;
        end else begin
            w_s2_imm = r_s1_imm;
        end
    end

    // Stage 1: capture formatted immediate and PC context on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_imm    <= {XLEN{1'b0}};
            r_s1_pc     <= {XLEN{1'b0}};
            r_s1_pc_rel <= 1'b0;
            r_s1_err    <= 1'b0;
        end else if (bus.flush) begin
            r_s1_valid  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_imm    <= w_imm;
                r_s1_pc     <= bus.pc;
                r_s1_pc_rel <= bus.pc_rel;
                r_s1_err    <= w_err;
            end
        end
    end

    // Stage 2: output registers, hold while stalled by the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_imm   <= {XLEN{1'b0}};
            r_s2_err   <= 1'b0;
        end else if (bus.flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_imm <= w_s2_imm;
                r_s2_err <= r_s1_err;
            end
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_ext_pipe -- directed self-checking bench for imm_ext_pipe.
// Instantiates an XLEN=32 and an XLEN=64 copy; expected values are
// hand-computed constants. Inputs change 1 time unit after the rising edge,
// outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_imm_ext_pipe;
    import imm_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   seen;

    imm_ext_pipe_if #(.XLEN(32)) if32 ();
    imm_ext_pipe_if #(.XLEN(64)) if64 ();

    imm_ext_pipe #(.XLEN(32), .OPW(OPW), .PC_REL_EN(1)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (if32.slave)
    );

    imm_ext_pipe #(.XLEN(64), .OPW(OPW), .PC_REL_EN(1)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (if64.slave)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input logic v, input logic [31:0] ins, input logic [31:0] p,
                           input logic [7:0] op, input logic rel);
        if32.in_valid = v;
        if32.instr    = ins;
        if32.pc       = p;
        if32.ext_op   = op;
        if32.pc_rel   = rel;
    endtask

    task automatic drive64(input logic v, input logic [31:0] ins, input logic [63:0] p,
                           input logic [7:0] op, input logic rel);
        if64.in_valid = v;
        if64.instr    = ins;
        if64.pc       = p;
        if64.ext_op   = op;
        if64.pc_rel   = rel;
    endtask

    initial begin
        rst = 1'b1;
        if32.flush = 1'b0; if32.out_ready = 1'b1;
        if64.flush = 1'b0; if64.out_ready = 1'b1;
        drive32(1'b0, 32'h0, 32'h0, 8'h00, 1'b0);
        drive64(1'b0, 32'h0, 64'h0, 8'h00, 1'b0);
        tick; tick;
        rst = 1'b0;

        // Reset state
        check_val("rst_valid",    {63'd0, if32.out_valid}, 64'd0);
        check_val("rst_imm",      {32'd0, if32.imm_out},   64'd0);
        check_val("rst_err",      {63'd0, if32.op_err},    64'd0);
        check_val("rst_in_ready", {63'd0, if32.in_ready},  64'd1);
        check_val("rst_valid64",  {63'd0, if64.out_valid}, 64'd0);

        // S12 then Z12 on the same word, back to back
        drive32(1'b1, 32'h02BFFC00, 32'h0, 8'h02, 1'b0);
        tick;
        check_val("lat_not_yet", {63'd0, if32.out_valid}, 64'd0);
        drive32(1'b1, 32'h02BFFC00, 32'h0, 8'h01, 1'b0);
        tick;
        drive32(1'b0, 32'h0, 32'h0, 8'h00, 1'b0);
        check_val("s12_valid", {63'd0, if32.out_valid}, 64'd1);
        check_val("s12_imm",   {32'd0, if32.imm_out},   64'h0000_0000_FFFF_FFFF);
        check_val("s12_err",   {63'd0, if32.op_err},    64'd0);
        tick;
        check_val("z12_valid", {63'd0, if32.out_valid}, 64'd1);
        check_val("z12_imm",   {32'd0, if32.imm_out},   64'h0000_0000_0000_0FFF);

        // F20 at XLEN=32
        drive32(1'b1, 32'h01000000, 32'h0, 8'h10, 1'b0);
        tick;
        drive32(1'b0, 32'h0, 32'h0, 8'h00, 1'b0);
        check_val("bubble_valid", {63'd0, if32.out_valid}, 64'd0);
        tick;
        check_val("f20_imm32", {32'd0, if32.imm_out}, 64'h0000_0000_8000_0000);

        // PC wrap: S26 = +8 added to 0xFFFF_FFFC
        drive32(1'b1, 32'h00000800, 32'hFFFF_FFFC, 8'h08, 1'b1);
        tick;
        drive32(1'b0, 32'h0, 32'h0, 8'h00, 1'b0);
        tick;
        check_val("wrap_valid", {63'd0, if32.out_valid}, 64'd1);
        check_val("wrap_imm",   {32'd0, if32.imm_out},   64'h0000_0000_0000_0004);
        tick;

        // XLEN=64: S16 negative plus PC, then F20 sign extension
        drive64(1'b1, 32'h02000000, 64'h0000_0000_1C00_0000, 8'h04, 1'b1);
        tick;
        drive64(1'b0, 32'h0, 64'h0, 8'h00, 1'b0);
        tick;
        check_val("s16_pc64_valid", {63'd0, if64.out_valid}, 64'd1);
        check_val("s16_pc64_imm",   if64.imm_out,           64'h0000_0000_1BFE_0000);
        drive64(1'b1, 32'h01000000, 64'h0, 8'h10, 1'b0);
        tick;
        drive64(1'b0, 32'h0, 64'h0, 8'h00, 1'b0);
        tick;
        check_val("f20_imm64", if64.imm_out, 64'hFFFF_FFFF_8000_0000);
        tick;

        // Stall: A (Z5) and B (Z6) fill both stages, C (S14) waits at input
        if32.out_ready = 1'b0;
        drive32(1'b1, 32'h00007C00, 32'h0, 8'h20, 1'b0);
        tick;
        drive32(1'b1, 32'h0000FC00, 32'h0, 8'h80, 1'b0);
        tick;
        drive32(1'b1, 32'h00800000, 32'h0, 8'h40, 1'b0);
        #1;
        for (int i = 0; i < 5; i++) begin
            check_val("stall_in_ready", {63'd0, if32.in_ready}, 64'd0);
            check_val("stall_imm",      {32'd0, if32.imm_out},  64'h0000_0000_0000_001F);
            tick;
        end
        check_val("stall_valid", {63'd0, if32.out_valid}, 64'd1);
        if32.out_ready = 1'b1;
        #1;
        check_val("release_in_ready", {63'd0, if32.in_ready}, 64'd1);
        tick;
        drive32(1'b0, 32'h0, 32'h0, 8'h00, 1'b0);
        check_val("order_b_valid", {63'd0, if32.out_valid}, 64'd1);
        check_val("order_b_imm",   {32'd0, if32.imm_out},   64'h0000_0000_0000_003F);
        tick;
        check_val("order_c_valid", {63'd0, if32.out_valid}, 64'd1);
        check_val("order_c_imm",   {32'd0, if32.imm_out},   64'h0000_0000_FFFF_8000);
        tick;
        check_val("drain_valid", {63'd0, if32.out_valid}, 64'd0);

        // Illegal selects: two bits set, then none
        drive32(1'b1, 32'h02BFFC00, 32'h0, 8'h03, 1'b0);
        tick;
        drive32(1'b1, 32'h02BFFC00, 32'h0, 8'h00, 1'b0);
        tick;
        drive32(1'b0, 32'h0, 32'h0, 8'h00, 1'b0);
        check_val("ill2_valid", {63'd0, if32.out_valid}, 64'd1);
        check_val("ill2_imm",   {32'd0, if32.imm_out},   64'd0);
        check_val("ill2_err",   {63'd0, if32.op_err},    64'd1);
        tick;
        check_val("ill0_valid", {63'd0, if32.out_valid}, 64'd1);
        check_val("ill0_imm",   {32'd0, if32.imm_out},   64'd0);
        check_val("ill0_err",   {63'd0, if32.op_err},    64'd1);
        tick;

        // Flush with both stages full and a new entry presented
        if32.out_ready = 1'b0;
        drive32(1'b1, 32'h02BFFC00, 32'h0, 8'h02, 1'b0);
        tick;
        drive32(1'b1, 32'h02BFFC00, 32'h0, 8'h01, 1'b0);
        tick;
        if32.flush = 1'b1;
        drive32(1'b1, 32'h00007C00, 32'h0, 8'h20, 1'b0);
        tick;
        if32.flush = 1'b0;
        if32.out_ready = 1'b1;
        drive32(1'b0, 32'h0, 32'h0, 8'h00, 1'b0);
        check_val("flush_valid", {63'd0, if32.out_valid}, 64'd0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (if32.out_valid) seen++;
            tick;
        end
        check_val("flush_no_output", 64'(seen), 64'd0);

        // Flush with s1 full, s2 empty: input accepted-looking but discarded
        drive32(1'b1, 32'h02BFFC00, 32'h0, 8'h02, 1'b0);
        tick;
        if32.flush = 1'b1;
        drive32(1'b1, 32'h0000FC00, 32'h0, 8'h80, 1'b0);
        #1;
        check_val("flush_in_ready", {63'd0, if32.in_ready}, 64'd1);
        tick;
        if32.flush = 1'b0;
        drive32(1'b0, 32'h0, 32'h0, 8'h00, 1'b0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (if32.out_valid) seen++;
            tick;
        end
        check_val("flush_discard", 64'(seen), 64'd0);
        drive32(1'b1, 32'h00007C00, 32'h0, 8'h20, 1'b0);
        tick;
        drive32(1'b0, 32'h0, 32'h0, 8'h00, 1'b0);
        tick;
        check_val("post_flush_valid", {63'd0, if32.out_valid}, 64'd1);
        check_val("post_flush_imm",   {32'd0, if32.imm_out},   64'h0000_0000_0000_001F);
        tick;

        // Reset during a stall
        if32.out_ready = 1'b0;
        drive32(1'b1, 32'h02BFFC00, 32'h0, 8'h02, 1'b0);
        tick;
        drive32(1'b1, 32'h02BFFC00, 32'h0, 8'h01, 1'b0);
        tick;
        drive32(1'b0, 32'h0, 32'h0, 8'h00, 1'b0);
        check_val("pre_rst_imm", {32'd0, if32.imm_out}, 64'h0000_0000_FFFF_FFFF);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_val("midrst_valid",    {63'd0, if32.out_valid}, 64'd0);
        check_val("midrst_imm",      {32'd0, if32.imm_out},   64'd0);
        check_val("midrst_err",      {63'd0, if32.op_err},    64'd0);
        check_val("midrst_in_ready", {63'd0, if32.in_ready},  64'd1);
        if32.out_ready = 1'b1;
        tick;
        check_val("midrst_dropped", {63'd0, if32.out_valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised, pipelined successor to the decode-stage immediate extender.
- Supports XLEN 32/64 and the LA64 immediate formats (si14, ui6). Adds an optional PC-relative adder for branch, jump, pcaddu12i and pcaddi targets.
- Two register stages with valid/ready handshake and flush. Sits between instruction decode and the ID/EX boundary.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- OPW, 8, width of the one-hot format select (ext_op).
- PC_REL_EN, 1, 1 instantiates the stage-2 PC adder; 0 forces pc_rel to be ignored.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill all in-flight entries (pipeline redirect).
- in_valid  in  1  input entry valid.
- in_ready  out  1  block can accept an entry this cycle.
- instr  in  32  raw instruction word.
- pc  in  XLEN  PC of the instruction.
- ext_op  in  OPW  one-hot format select (bit map below).
- pc_rel  in  1  add pc to the extended immediate.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- imm_out  out  XLEN  extended immediate, or pc+imm when pc_rel.
- op_err  out  1  ext_op was not one-hot; travels with the result.

Behaviour:
- ext_op bit map, sign-extend to XLEN where marked S:
  - [0] Z12 = zero-extend instr[21:10].
  - [1] S12 = instr[21:10], S.
  - [2] S16 = {instr[25:10], 2'b00}, S.
  - [3] S26 = {instr[9:0], instr[25:10], 2'b00}, S.
  - [4] F20 = {instr[24:5], 12'b0}, S from bit 31.
  - [5] Z5 = zero-extend instr[14:10].
  - [6] S14 = {instr[23:10], 2'b00}, S.
  - [7] Z6 = zero-extend instr[15:10].
- Illegal ext_op (zero or more than one bit set): imm = 0, op_err = 1. The entry still flows through; no stall, no drop.
- Stage 1 (s1): on in_valid && in_ready, registers the extended imm, pc, pc_rel and op_err.
- Stage 2 (s2): computes imm_out = pc_rel ? s1_pc + s1_imm : s1_imm, modulo 2^XLEN, wrap silently.
- With PC_REL_EN = 0: imm_out = s1_imm always.
- Output: s2 registers drive imm_out and op_err directly; no combinational path from input to output.
- Latency: 2 cycles from accept to out_valid when unstalled. Throughput 1 entry/cycle.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; this is the only such path).
  - Data in any stage holds stable while its valid is high and it is not advancing.
  - out_valid = s2_valid. It may not drop without out_ready, except on flush or rst.
- Flush:
  - On a flush cycle, s1_valid and s2_valid go 0 at the next edge.
  - Any input presented in the same cycle is discarded, even with in_valid && in_ready.
  - in_ready is still driven normally during flush.
- Simultaneous out_ready and in_valid with both stages full: shift through with no bubble.
- rst has priority over flush:
  - All valids go 0.
  - imm_out = 0 and op_err = 0.
  - in_ready = 1 on the cycle after rst deasserts.
  - Reset mid-stall drops all entries.
- At XLEN=32, S extension covers 32 bits and Z6 still produces a 6-bit zero-extended value.

Decomposition:
- Shared package imm_pkg:
  - ext_op bit-index constants EXT_Z12 … EXT_Z6.
  - OPW.
  - The imm_fmt_e typedef for bench and decoder use.
- Sub-module imm_ext_comb (instr, ext_op → imm[XLEN-1:0], op_err): the purely combinational formatter, reused by the decoder for non-pipelined paths.

Test Plan:
1. XLEN=32, instr=32'h02BFFC00 (instr[21:10]=12'hFFF), ext_op=S12, pc_rel=0 → 2 cycles later out_valid=1, imm_out=32'hFFFFFFFF, op_err=0. Same instr with Z12 → 32'h00000FFF.
2. XLEN=64, pc=64'h0000_0000_1C00_0000, ext_op=S16 with instr[25:10]=16'h8000, pc_rel=1 → imm_out=64'h0000_0000_1BFE_0000.
3. Stall: fill both stages, hold out_ready=0 for 5 cycles → in_ready=0, imm_out stable. Release out_ready → two results in back-to-back cycles, in original order.
4. ext_op=8'b0000_0011 and ext_op=0 → imm_out=0, op_err=1, entry not dropped.
5. Flush while s1 and s2 are valid, with in_valid=1 in the same cycle → next cycle out_valid=0, and no output appears for any of those three entries.
6. Assert rst during a stall → next cycle out_valid=0, imm_out=0, in_ready=1. Wrap check: pc=32'hFFFF_FFFC with S26 imm=+8 and pc_rel=1 → imm_out=32'h0000_0004.
